// File: rtl/autobus_gen.sv
// Framed streaming traffic generator: packets of sop_len beats, frames of sof_len
// packets, optional inter-packet gap, four data modes, valid/ready backpressure.
module autobus_gen #(
  parameter int              DWID      = 16,
  parameter int              CWID      = 16,
  parameter logic [DWID-1:0] LFSR_TAPS = DWID'(16'hB400)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [DWID-1:0] seed,
  input  logic [CWID-1:0] sop_len,
  input  logic [CWID-1:0] sof_len,
  input  logic [CWID-1:0] pkt_interval,
  input  logic            rdy,
  output logic            sop,
  output logic            eop,
  output logic            sof,
  output logic            eof,
  output logic [DWID-1:0] dat,
  output logic            dav,
  output logic [31:0]     frm_cnt,
  output logic            busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef struct packed {
    logic            sop;
    logic            eop;
    logic            sof;
    logic            eof;
    logic [DWID-1:0] dat;
  } beat_t;

  function automatic logic [DWID-1:0] lfsr_step(input logic [DWID-1:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_TAPS : '0);
  endfunction

  function automatic beat_t present(input logic [CWID-1:0] b, input logic [CWID-1:0] p,
                                    input logic [CWID-1:0] len, input logic [CWID-1:0] flen,
                                    input logic [1:0] md, input logic [DWID-1:0] sd,
                                    input logic [DWID-1:0] lf);
    beat_t           r;
    logic [DWID-1:0] bx;
    logic [DWID-1:0] px;
    bx    = DWID'(b);
    px    = DWID'(p);
    r.sop = (b == '0);
    r.eop = (b == len - CWID'(1));
    r.sof = r.sop && (p == '0);
    r.eof = r.eop && (p == flen - CWID'(1));
    case (md)
      2'd0:    r.dat = bx;
      2'd1:    r.dat = {px[DWID/2-1:0], bx[DWID-DWID/2-1:0]};
      2'd2:    r.dat = lf;
      default: r.dat = sd;
    endcase
    return r;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [DWID-1:0] seed_q, seed_d;
  logic [CWID-1:0] len_q, len_d, flen_q, flen_d, intv_q, intv_d;
  logic [CWID-1:0] beat_q, beat_d, pkt_q, pkt_d, gap_q, gap_d;
  logic [DWID-1:0] lfsr_q, lfsr_d;
  beat_t           out_q, out_d;
  logic            dav_q, dav_d;
  logic [31:0]     frm_q, frm_d;
  logic            busy_q;

  // Zero lengths behave as one; a zero LFSR seed would lock up, so it becomes all-ones.
  logic [CWID-1:0] in_len, in_flen;
  logic [DWID-1:0] in_seed, lfsr_nxt;
  beat_t           start_beat;
  logic            accept;

  assign in_len     = (sop_len == '0) ? CWID'(1) : sop_len;
  assign in_flen    = (sof_len == '0) ? CWID'(1) : sof_len;
  assign in_seed    = (seed == '0) ? '1 : seed;
  assign lfsr_nxt   = lfsr_step(lfsr_q);
  assign start_beat = present('0, '0, in_len, in_flen, mode, seed, in_seed);
  assign accept     = dav_q && rdy;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d = state_q;
    mode_d  = mode_q;
    seed_d  = seed_q;
    len_d   = len_q;
    flen_d  = flen_q;
    intv_d  = intv_q;
    beat_d  = beat_q;
    pkt_d   = pkt_q;
    gap_d   = gap_q;
    lfsr_d  = lfsr_q;
    out_d   = out_q;
    dav_d   = dav_q;
    frm_d   = frm_q;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          {mode_d, seed_d, len_d, flen_d, intv_d} = {mode, seed, in_len, in_flen, pkt_interval};
          beat_d  = '0;
          pkt_d   = '0;
          lfsr_d  = in_seed;
          out_d   = start_beat;
          dav_d   = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          lfsr_d = lfsr_nxt;
          if (!out_q.eop) begin
            beat_d = beat_q + CWID'(1);
            out_d  = present(beat_q + CWID'(1), pkt_q, len_q, flen_q, mode_q, seed_q, lfsr_nxt);
          end else if (!out_q.eof) begin
            beat_d = '0;
            pkt_d  = pkt_q + CWID'(1);
            if (intv_q != '0) begin
              gap_d   = '0;
              dav_d   = 1'b0;
              {out_d.sop, out_d.eop, out_d.sof, out_d.eof} = 4'b0000;
              state_d = ST_GAP;
            end else begin
              out_d = present('0, pkt_q + CWID'(1), len_q, flen_q, mode_q, seed_q, lfsr_nxt);
            end
          end else begin
            frm_d  = frm_q + 32'd1;
            beat_d = '0;
            pkt_d  = '0;
            if (en) begin
              {mode_d, seed_d, len_d, flen_d, intv_d} = {mode, seed, in_len, in_flen, pkt_interval};
              lfsr_d = in_seed;
              if (pkt_interval != '0) begin
                gap_d   = '0;
                dav_d   = 1'b0;
                {out_d.sop, out_d.eop, out_d.sof, out_d.eof} = 4'b0000;
                state_d = ST_GAP;
              end else begin
                out_d = start_beat;
              end
            end else begin
              dav_d   = 1'b0;
              {out_d.sop, out_d.eop, out_d.sof, out_d.eof} = 4'b0000;
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        gap_d = gap_q + CWID'(1);
        if (gap_q == intv_q - CWID'(1)) begin
          out_d   = present(beat_q, pkt_q, len_q, flen_q, mode_q, seed_q, lfsr_q);
          dav_d   = 1'b1;
          state_d = ST_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      seed_q  <= '0;
      len_q   <= '0;
      flen_q  <= '0;
      intv_q  <= '0;
      beat_q  <= '0;
      pkt_q   <= '0;
      gap_q   <= '0;
      lfsr_q  <= in_seed;
      out_q   <= '0;
      dav_q   <= 1'b0;
      frm_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      len_q   <= len_d;
      flen_q  <= flen_d;
      intv_q  <= intv_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      gap_q   <= gap_d;
      lfsr_q  <= lfsr_d;
      out_q   <= out_d;
      dav_q   <= dav_d;
      frm_q   <= frm_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign sop     = out_q.sop;
  assign eop     = out_q.eop;
  assign sof     = out_q.sof;
  assign eof     = out_q.eof;
  assign dat     = out_q.dat;
  assign dav     = dav_q;
  assign frm_cnt = frm_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_autobus_gen.sv
// Directed bench for autobus_gen: framing, backpressure, gaps, data modes, degenerate
// lengths and asynchronous reset, each against hand-computed expectations.
module tb_autobus_gen;

  logic        clk = 1'b0;
  logic        rst_n, en, rdy;
  logic [1:0]  mode;
  logic [15:0] seed, sop_len, sof_len, pkt_interval;
  logic        sop, eop, sof, eof, dav, busy;
  logic [15:0] dat;
  logic [31:0] frm_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned exp_frm  = 0;
  logic [15:0] exp_dat [8];

  autobus_gen #(.DWID(16), .CWID(16), .LFSR_TAPS(16'hB400)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .seed(seed),
    .sop_len(sop_len), .sof_len(sof_len), .pkt_interval(pkt_interval), .rdy(rdy),
    .sop(sop), .eop(eop), .sof(sof), .eof(eof), .dat(dat), .dav(dav),
    .frm_cnt(frm_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] m, input logic [15:0] s, input logic [15:0] sl,
                     input logic [15:0] fl, input logic [15:0] iv);
    mode = m; seed = s; sop_len = sl; sof_len = fl; pkt_interval = iv;
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] d, input logic s, input logic e,
                          input logic sf, input logic ef);
    check({tag, " dav"}, 32'(dav), 32'd1);
    check({tag, " dat"}, 32'(dat), 32'(d));
    check({tag, " flags"}, {28'd0, sop, eop, sof, eof}, {28'd0, s, e, sf, ef});
  endtask

  // Runs one frame started by an en pulse, checking dat against exp_dat[0..n-1].
  task automatic run_dat(input string tag, input int n);
    en = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s dav%0d", tag, i), 32'(dav), 32'd1);
      check($sformatf("%s dat%0d", tag, i), 32'(dat), 32'(exp_dat[i]));
      step();
    end
    check({tag, " end dav"}, 32'(dav), 32'd0);
    exp_frm++;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; rdy = 1'b1;
    cfg(2'd0, 16'h0, 16'd4, 16'd2, 16'd0);
    #12;
    check("rst dav", 32'(dav), 32'd0);
    check("rst flags", {28'd0, sop, eop, sof, eof}, 32'd0);
    check("rst dat", 32'(dat), 32'd0);
    check("rst frm_cnt", frm_cnt, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic stream: 2 packets of 4 beats, en pulsed for one cycle.
    en = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_beat($sformatf("basic b%0d", i), 16'(i % 4), (i % 4) == 0, (i % 4) == 3, i == 0, i == 7);
      step();
    end
    exp_frm++;
    check("basic idle dav", 32'(dav), 32'd0);
    check("basic idle busy", 32'(busy), 32'd0);
    check("basic frm_cnt", frm_cnt, 32'(exp_frm));

    // Backpressure: rdy low for 3 cycles while dat=2 is presented.
    en = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_beat($sformatf("bp b%0d", i), 16'(i % 4), (i % 4) == 0, (i % 4) == 3, i == 0, i == 7);
      if (i == 2) begin
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
          step();
          chk_beat($sformatf("bp hold%0d", k), 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rdy = 1'b1;
      end
      step();
    end
    exp_frm++;
    check("bp idle dav", 32'(dav), 32'd0);
    check("bp frm_cnt", frm_cnt, 32'(exp_frm));

    // Gap: 2 beats/packet, 3 packets/frame, 5 idle cycles, en held for two frames.
    cfg(2'd0, 16'h0, 16'd2, 16'd3, 16'd5);
    en = 1'b1;
    step();
    for (int p = 0; p < 6; p++) begin
      for (int b = 0; b < 2; b++) begin
        if (p == 5 && b == 1) en = 1'b0;
        chk_beat($sformatf("gap p%0d b%0d", p, b), 16'(b), b == 0, b == 1,
                 (p % 3 == 0) && (b == 0), (p % 3 == 2) && (b == 1));
        step();
      end
      if (p == 2) exp_frm++;
      if (p < 5) begin
        for (int g = 0; g < 5; g++) begin
          check($sformatf("gap p%0d idle%0d", p, g), 32'(dav), 32'd0);
          step();
        end
        if (p == 2) check("gap frm_cnt mid", frm_cnt, 32'(exp_frm));
      end
    end
    exp_frm++;
    check("gap end dav", 32'(dav), 32'd0);
    check("gap end busy", 32'(busy), 32'd0);
    check("gap frm_cnt", frm_cnt, 32'(exp_frm));

    // Data modes.
    cfg(2'd1, 16'h0, 16'd3, 16'd2, 16'd0);
    exp_dat[0] = 16'h0000; exp_dat[1] = 16'h0001; exp_dat[2] = 16'h0002;
    exp_dat[3] = 16'h0100; exp_dat[4] = 16'h0101; exp_dat[5] = 16'h0102;
    run_dat("mode1", 6);
    cfg(2'd2, 16'h0001, 16'd4, 16'd1, 16'd0);
    exp_dat[0] = 16'h0001; exp_dat[1] = 16'hB400; exp_dat[2] = 16'h5A00; exp_dat[3] = 16'h2D00;
    run_dat("mode2", 4);
    cfg(2'd2, 16'h0000, 16'd1, 16'd1, 16'd0);
    exp_dat[0] = 16'hFFFF;
    run_dat("mode2 seed0", 1);
    cfg(2'd3, 16'hA5A5, 16'd2, 16'd2, 16'd0);
    for (int i = 0; i < 4; i++) exp_dat[i] = 16'hA5A5;
    run_dat("mode3", 4);
    check("modes frm_cnt", frm_cnt, 32'(exp_frm));

    // Zero lengths: every beat is a single-beat frame.
    cfg(2'd0, 16'h0, 16'd0, 16'd0, 16'd0);
    en = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) en = 1'b0;
      chk_beat($sformatf("zero b%0d", i), 16'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      exp_frm++;
      check($sformatf("zero frm%0d", i), frm_cnt, 32'(exp_frm));
    end
    check("zero idle dav", 32'(dav), 32'd0);
    check("zero idle busy", 32'(busy), 32'd0);

    // Reset mid-packet, then restart with en held high.
    cfg(2'd0, 16'h0, 16'd4, 16'd1, 16'd0);
    en = 1'b1;
    step();
    en = 1'b0;
    step();
    chk_beat("pre-rst", 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid-rst dav", 32'(dav), 32'd0);
    check("mid-rst flags", {28'd0, sop, eop, sof, eof}, 32'd0);
    check("mid-rst dat", 32'(dat), 32'd0);
    check("mid-rst frm_cnt", frm_cnt, 32'd0);
    check("mid-rst busy", 32'(busy), 32'd0);
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    en = 1'b0;
    chk_beat("post-rst b0", 16'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("post-rst busy", 32'(busy), 32'd1);
    check("post-rst frm_cnt", frm_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
